// File: rtl/rej_count_writer_pkg.sv
// Shared constants and types for the reject-count writer and its FIFO.
// Holds FIFO depth, credit-width helper and writer FSM state type.
package rej_count_writer_pkg;

  localparam int FIFO_DEPTH = 3;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CREDIT_W = credit_w(FIFO_DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    FULL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/rej_credit_counter.sv
// Up/down counter of free forwarder FIFO entries, with sticky err_credit.
// Ports: clk, rst, push, retire -> credits, err_credit.
module rej_credit_counter
  import rej_count_writer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       retire,
  output logic [credit_w(DEPTH)-1:0] credits,
  output logic                       err_credit
);

  localparam int CW = credit_w(DEPTH);
  localparam logic [CW-1:0] MAXC = CW'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits    <= MAXC;
      err_credit <= 1'b0;
    end else begin
      unique case (1'b1)
        push && !retire: credits <= credits - 1'b1;
        retire && !push: begin
          // A retire with nothing outstanding is a forwarder bug.
          if (credits == MAXC) err_credit <= 1'b1;
          else                 credits    <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rej_count_writer.sv
// Counts consecutive rejects and pushes the count to the forwarder FIFO on accept.
// Ports: decision handshake in, entry_retired in, rej_count_out/shift_out/credits/err_* out; REJ_COUNT_WRITER_STATS_EN adds total_accepts/total_rejects.
module rej_count_writer
  import rej_count_writer_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int DEPTH       = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       decision_valid,
  input  logic                       decision_accept,
  output logic                       decision_ready,
  input  logic                       entry_retired,
  output logic [COUNT_WIDTH-1:0]     rej_count_out,
  output logic                       shift_out,
  output logic [credit_w(DEPTH)-1:0] credits,
`ifdef REJ_COUNT_WRITER_STATS_EN
  output logic [31:0]                total_accepts,
  output logic [31:0]                total_rejects,
`endif
  output logic                       err_overflow,
  output logic                       err_credit
);

  localparam int CW = credit_w(DEPTH);

  logic [COUNT_WIDTH-1:0] pending;
  wr_state_e              state;
  logic                   hs_acc;
  logic                   hs_rej;

  // FULL tracks credits==0; a same-cycle retire frees a slot.
  assign decision_ready = !(decision_accept && (state == FULL)
                            && !entry_retired);
  assign hs_acc = decision_valid && decision_ready && decision_accept;
  assign hs_rej = decision_valid && !decision_accept;

  rej_credit_counter #(
    .DEPTH(DEPTH)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .push      (hs_acc),
    .retire    (entry_retired),
    .credits   (credits),
    .err_credit(err_credit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending       <= '0;
      rej_count_out <= '0;
      shift_out     <= 1'b0;
      err_overflow  <= 1'b0;
      state         <= RUN;
    end else begin
      shift_out <= hs_acc;
      if (hs_acc) begin
        rej_count_out <= pending;
        pending       <= '0;
      end else if (hs_rej) begin
        if (&pending) err_overflow <= 1'b1;
        else          pending      <= pending + 1'b1;
      end
      unique case (state)
        RUN:
          if (hs_acc && !entry_retired && credits == CW'(1))
            state <= FULL;
        FULL:
          if (entry_retired && !hs_acc)
            state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef REJ_COUNT_WRITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_accepts <= '0;
      total_rejects <= '0;
    end else begin
      if (hs_acc) total_accepts <= total_accepts + 1'b1;
      if (hs_rej) total_rejects <= total_rejects + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rej_count_writer.sv
// Self-checking bench for rej_count_writer (default COUNT_WIDTH=8, DEPTH=3).
// Scoreboard queue of expected pushed counts; optional stats checked under REJ_COUNT_WRITER_STATS_EN.
module tb_rej_count_writer;
  import rej_count_writer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       decision_valid;
  logic       decision_accept;
  logic       decision_ready;
  logic       entry_retired;
  logic [7:0] rej_count_out;
  logic       shift_out;
  logic [1:0] credits;
  logic       err_overflow;
  logic       err_credit;
`ifdef REJ_COUNT_WRITER_STATS_EN
  logic [31:0] total_accepts;
  logic [31:0] total_rejects;
`endif

  always #5 clk = ~clk;

  rej_count_writer #(
    .COUNT_WIDTH(8),
    .DEPTH      (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .decision_valid (decision_valid),
    .decision_accept(decision_accept),
    .decision_ready (decision_ready),
    .entry_retired  (entry_retired),
    .rej_count_out  (rej_count_out),
    .shift_out      (shift_out),
    .credits        (credits),
`ifdef REJ_COUNT_WRITER_STATS_EN
    .total_accepts  (total_accepts),
    .total_rejects  (total_rejects),
`endif
    .err_overflow   (err_overflow),
    .err_credit     (err_credit)
  );

  int total = 0;
  int bad   = 0;
  int m_pend, m_cred, m_last, m_acc, m_rej;
  bit m_ovf, m_cerr;
  int sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_cred = 3; m_last = 0;
    m_acc = 0; m_rej = 0; m_ovf = 0; m_cerr = 0;
    sb.delete();
  endtask

  task automatic cyc(input bit v, input bit a, input bit r);
    bit rdy, hs, push;
    @(negedge clk);
    decision_valid  = v;
    decision_accept = a;
    entry_retired   = r;
    #1;
    rdy = !(a && m_cred == 0 && !r);
    chk("ready", decision_ready, rdy);
    hs   = v && rdy;
    push = hs && a;
    if (hs && !a) begin
      m_rej++;
      if (m_pend == 255) m_ovf = 1;
      else m_pend++;
    end
    if (push) begin
      sb.push_back(m_pend);
      m_pend = 0;
      m_acc++;
    end
    if (push && !r) m_cred--;
    else if (r && !push) begin
      if (m_cred == 3) m_cerr = 1;
      else m_cred++;
    end
    @(posedge clk);
    #1;
    if (shift_out) begin
      if (sb.size() == 0) chk("spurious_shift", shift_out, 0);
      else begin
        m_last = sb.pop_front();
        chk("rej_count", rej_count_out, m_last);
      end
    end else begin
      if (sb.size() != 0) begin
        chk("missing_shift", shift_out, 1);
        void'(sb.pop_front());
      end
      chk("rej_hold", rej_count_out, m_last);
    end
    chk("credits", credits, m_cred);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_credit", err_credit, m_cerr);
`ifdef REJ_COUNT_WRITER_STATS_EN
    chk("total_accepts", total_accepts, m_acc);
    chk("total_rejects", total_rejects, m_rej);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    decision_valid  = 1'b0;
    decision_accept = 1'b0;
    entry_retired   = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_credits", credits, 3);
    chk("rst_shift", shift_out, 0);
    chk("rst_rej", rej_count_out, 0);
    chk("rst_err_ovf", err_overflow, 0);
    chk("rst_err_cred", err_credit, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    decision_valid  = 1'b0;
    decision_accept = 1'b0;
    entry_retired   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_credits", credits, 3);
    chk("init_shift", shift_out, 0);
    chk("init_rej", rej_count_out, 0);
    chk("init_ready", decision_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // 5 rejects then accept
    repeat (5) cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("t1_credits", credits, 2);
    chk("t1_rej", rej_count_out, 5);

    // fill the FIFO, stall, count rejects, retire-in-same-cycle accept
    cyc(0, 0, 1);
    repeat (3) cyc(1, 1, 0);
    chk("full_credits", credits, 0);
    cyc(1, 1, 0);
    chk("full_ready", decision_ready, 0);
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("same_cyc_rej", rej_count_out, 2);
    chk("same_cyc_credits", credits, 0);
    repeat (3) cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("err_credit_set", err_credit, 1);
    chk("err_credit_cred", credits, 3);

    // saturation
    do_reset();
    repeat (257) cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("ovf_rej", rej_count_out, 255);
    chk("ovf_flag", err_overflow, 1);

    // random traffic with legal retires
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 3) == 0,
          (m_cred < 3) && (($urandom % 4) == 0));
    end

    // stats pattern
    do_reset();
    repeat (4) cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("stats_last_rej", rej_count_out, 3);
`ifdef REJ_COUNT_WRITER_STATS_EN
    chk("stats_rejects", total_rejects, 7);
    chk("stats_accepts", total_accepts, 2);
`endif

    // reset the cycle after an accept
    do_reset();
    repeat (4) cyc(1, 0, 0);
    @(negedge clk);
    decision_valid  = 1'b1;
    decision_accept = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_shift", shift_out, 1);
    chk("pre_rst_rej", rej_count_out, 4);
    rst = 1'b1;
    decision_valid = 1'b0;
    #1;
    chk("mid_rst_shift", shift_out, 0);
    chk("mid_rst_credits", credits, 3);
    chk("mid_rst_rej", rej_count_out, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // reset with pending rejects clears the count
    repeat (3) cyc(1, 0, 0);
    do_reset();
    cyc(1, 1, 0);
    chk("post_rst_pending", rej_count_out, 0);
    cyc(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
